// File: rtl/serial_pkg.sv
// serial_pkg: shared UART state encoding and frame constants
package serial_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } serialState_t;
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;
    localparam int FRAME_BITS = 1 + DATA_BITS + STOP_BITS;
    localparam int DEFAULT_CLKS_PER_BIT = 5208;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered count/full/empty and sticky overflow
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IN_PUSH,
    input  logic [WIDTH-1:0] IN_DATA,
    input  logic             IN_POP,
    output logic [WIDTH-1:0] OUT_DATA,
    output logic             OUT_FULL,
    output logic             OUT_EMPTY,
    output logic [AW:0]      OUT_COUNT,
    output logic             OUT_OVERFLOW
);
    localparam int DEPTH = 2 ** AW;
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wrPtr, rdPtr;
    logic doPush, doPop;
    logic [AW:0] countNext;
    // full is taken from the registered flag, so a push while full is dropped even if a pop happens this cycle
    assign doPush = IN_PUSH && !OUT_FULL;
    assign doPop = IN_POP && !OUT_EMPTY;
    assign countNext = OUT_COUNT + CW'(doPush) - CW'(doPop);
    assign OUT_DATA = mem[rdPtr];
    // storage array, no reset needed
    always_ff @(posedge CLK) begin
        if (doPush) mem[wrPtr] <= IN_DATA;
    end
    // pointers, occupancy and flags
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wrPtr <= '0;
            rdPtr <= '0;
            OUT_COUNT <= '0;
            OUT_FULL <= 1'b0;
            OUT_EMPTY <= 1'b1;
            OUT_OVERFLOW <= 1'b0;
        end else begin
            wrPtr <= wrPtr + AW'(doPush);
            rdPtr <= rdPtr + AW'(doPop);
            OUT_COUNT <= countNext;
            OUT_FULL <= countNext == CW'(DEPTH);
            OUT_EMPTY <= countNext == '0;
            OUT_OVERFLOW <= OUT_OVERFLOW | (IN_PUSH && OUT_FULL);
        end
    end
endmodule

// File: rtl/serial_tx_fifo.sv
// serial_tx_fifo: buffered 8N1 UART transmitter with back-to-back frames
module serial_tx_fifo
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_AW = 4,
    parameter int CNT_W = 13
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IN_WR,
    input  logic [7:0]       IN_DATA,
    output logic             OUT_FULL,
    output logic             OUT_EMPTY,
    output logic [FIFO_AW:0] OUT_COUNT,
    output logic             OUT_OVERFLOW,
    output logic             OUT_BUSY,
    output logic             OUT_SERIAL_TX
);
    serialState_t state, stateNext;
    logic [CNT_W-1:0] baudCnt, baudNext;
    logic [2:0] bitIdx, bitNext;
    logic [DATA_BITS-1:0] shiftReg, shiftNext, headData;
    logic txNext, pop, baudDone;
    sync_fifo #(.WIDTH(DATA_BITS), .AW(FIFO_AW)) fifo (
        .CLK(CLK),
        .RESET(RESET),
        .IN_PUSH(IN_WR),
        .IN_DATA(IN_DATA),
        .IN_POP(pop),
        .OUT_DATA(headData),
        .OUT_FULL(OUT_FULL),
        .OUT_EMPTY(OUT_EMPTY),
        .OUT_COUNT(OUT_COUNT),
        .OUT_OVERFLOW(OUT_OVERFLOW)
    );
    assign baudDone = baudCnt == CNT_W'(CLKS_PER_BIT - 1);
    assign OUT_BUSY = state != IDLE;
    // next-state, pop and line level; TX follows the current state one cycle later
    always_comb begin
        stateNext = state;
        baudNext = baudDone ? '0 : baudCnt + 1'b1;
        bitNext = bitIdx;
        shiftNext = shiftReg;
        pop = 1'b0;
        txNext = 1'b1;
        case (state)
            IDLE: begin
                baudNext = '0;
                if (!OUT_EMPTY) begin
                    pop = 1'b1;
                    shiftNext = headData;
                    bitNext = '0;
                    stateNext = START;
                end
            end
            START: begin
                txNext = 1'b0;
                stateNext = baudDone ? DATA : START;
            end
            DATA: begin
                txNext = shiftReg[0];
                if (baudDone) begin
                    shiftNext = shiftReg >> 1;
                    bitNext = bitIdx + 1'b1;
                    stateNext = bitIdx == 3'(DATA_BITS - 1) ? STOP : DATA;
                end
            end
            default: begin
                if (baudDone) begin
                    pop = !OUT_EMPTY;
                    shiftNext = OUT_EMPTY ? shiftReg : headData;
                    bitNext = '0;
                    stateNext = OUT_EMPTY ? IDLE : START;
                end
            end
        endcase
    end
    // FSM, shifter and line registers; reset drives the line high at once
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            baudCnt <= '0;
            bitIdx <= '0;
            shiftReg <= '0;
            OUT_SERIAL_TX <= 1'b1;
        end else begin
            state <= stateNext;
            baudCnt <= baudNext;
            bitIdx <= bitNext;
            shiftReg <= shiftNext;
            OUT_SERIAL_TX <= txNext;
        end
    end
endmodule

// File: tb/tb_serial_tx_fifo.sv
// tb_serial_tx_fifo: directed checks of the buffered UART transmitter
module tb_serial_tx_fifo;
    localparam int CPB = 4;
    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic IN_WR = 1'b0;
    logic [7:0] IN_DATA = 8'h00;
    logic OUT_FULL, OUT_EMPTY, OUT_OVERFLOW, OUT_BUSY, OUT_SERIAL_TX;
    logic [4:0] OUT_COUNT;
    int total = 0;
    int bad = 0;
    logic txLog [0:1023];
    int logN = 0;
    bit logOn = 0;

    serial_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(4), .CNT_W(13)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .IN_WR(IN_WR),
        .IN_DATA(IN_DATA),
        .OUT_FULL(OUT_FULL),
        .OUT_EMPTY(OUT_EMPTY),
        .OUT_COUNT(OUT_COUNT),
        .OUT_OVERFLOW(OUT_OVERFLOW),
        .OUT_BUSY(OUT_BUSY),
        .OUT_SERIAL_TX(OUT_SERIAL_TX)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
        if (logOn && logN < 1024) begin
            txLog[logN] = OUT_SERIAL_TX;
            logN++;
        end
    endtask

    task automatic do_reset();
        IN_WR = 1'b0;
        RESET = 1'b1;
        #3;
        RESET = 1'b0;
        tick();
    endtask

    task automatic write_byte(input logic [7:0] d);
        IN_WR = 1'b1;
        IN_DATA = d;
        tick();
        IN_WR = 1'b0;
    endtask

    task automatic check_frame(input logic [7:0] d, input int skip);
        logic e;
        int n;
        n = 0;
        for (int b = 0; b < 10; b++) begin
            e = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : d[b-1];
            for (int j = 0; j < CPB; j++) begin
                if (n >= skip) begin
                    tick();
                    total++;
                    if (OUT_SERIAL_TX !== e) begin
                        bad++;
                        $display("FAIL frame_%02h bit%0d cyc%0d: tx=%b want=%b", d, b, j, OUT_SERIAL_TX, e);
                    end
                end
                n++;
            end
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick();
        tick();
        #2;
        RESET = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            total++;
            if ({OUT_SERIAL_TX, OUT_BUSY, OUT_EMPTY, OUT_FULL, OUT_OVERFLOW, OUT_COUNT} !== {5'b10100, 5'd0}) begin
                bad++;
                $display("FAIL reset_idle cyc%0d: tx/busy/empty/full/ovf/count=%b%b%b%b%b/%0d want=10100/0",
                         i, OUT_SERIAL_TX, OUT_BUSY, OUT_EMPTY, OUT_FULL, OUT_OVERFLOW, OUT_COUNT);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        write_byte(8'hA5);
        total++;
        if (OUT_COUNT !== 5'd1 || OUT_SERIAL_TX !== 1'b1) begin
            bad++;
            $display("FAIL single_write: count=%0d tx=%b want count=1 tx=1", OUT_COUNT, OUT_SERIAL_TX);
        end
        tick();
        total++;
        if (OUT_COUNT !== 5'd0 || OUT_BUSY !== 1'b1 || OUT_SERIAL_TX !== 1'b1) begin
            bad++;
            $display("FAIL single_pop: count=%0d busy=%b tx=%b want 0 1 1", OUT_COUNT, OUT_BUSY, OUT_SERIAL_TX);
        end
        check_frame(8'hA5, 0);
        total++;
        if (OUT_BUSY !== 1'b0 || OUT_EMPTY !== 1'b1) begin
            bad++;
            $display("FAIL single_done: busy=%b empty=%b want 0 1", OUT_BUSY, OUT_EMPTY);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        write_byte(8'h00);
        total++;
        if (OUT_COUNT !== 5'd1) begin
            bad++;
            $display("FAIL burst_count0: count=%0d want 1", OUT_COUNT);
        end
        write_byte(8'hFF);
        total++;
        if (OUT_COUNT !== 5'd1) begin
            bad++;
            $display("FAIL burst_count1: count=%0d want 1", OUT_COUNT);
        end
        write_byte(8'h55);
        total++;
        if (OUT_COUNT !== 5'd2 || OUT_SERIAL_TX !== 1'b0) begin
            bad++;
            $display("FAIL burst_count2: count=%0d tx=%b want 2 0", OUT_COUNT, OUT_SERIAL_TX);
        end
        check_frame(8'h00, 1);
        total++;
        if (OUT_COUNT !== 5'd1) begin
            bad++;
            $display("FAIL burst_after1: count=%0d want 1", OUT_COUNT);
        end
        check_frame(8'hFF, 0);
        total++;
        if (OUT_COUNT !== 5'd0 || OUT_BUSY !== 1'b1) begin
            bad++;
            $display("FAIL burst_after2: count=%0d busy=%b want 0 1", OUT_COUNT, OUT_BUSY);
        end
        check_frame(8'h55, 0);
        total++;
        if (OUT_BUSY !== 1'b0) begin
            bad++;
            $display("FAIL burst_done: busy=%b want 0", OUT_BUSY);
        end
    endtask

    task automatic test_overflow();
        logic [4:0] ec;
        logic [7:0] d;
        logic e;
        bit ok;
        do_reset();
        logN = 0;
        logOn = 1;
        for (int i = 0; i < 20; i++) begin
            write_byte(8'h30 + 8'(i));
            ec = (i == 0) ? 5'd1 : (i > 16 ? 5'd16 : 5'(i));
            total++;
            if (OUT_COUNT !== ec || OUT_FULL !== (i >= 16) || OUT_OVERFLOW !== (i >= 17)) begin
                bad++;
                $display("FAIL ovf_fill w%0d: count=%0d full=%b ovf=%b want %0d %b %b",
                         i, OUT_COUNT, OUT_FULL, OUT_OVERFLOW, ec, i >= 16, i >= 17);
            end
        end
        while (logN < 3 + 17 * 40) tick();
        logOn = 0;
        for (int f = 0; f < 17; f++) begin
            d = 8'h30 + 8'(f);
            ok = 1;
            for (int b = 0; b < 10; b++) begin
                e = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : d[b-1];
                for (int j = 0; j < CPB; j++)
                    if (txLog[2 + 40 * f + 4 * b + j] !== e) ok = 0;
            end
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL ovf_frame%0d: tx pattern differs from byte %02h", f, d);
            end
        end
        total++;
        if (txLog[682] !== 1'b1 || OUT_BUSY !== 1'b0 || OUT_OVERFLOW !== 1'b1 || OUT_COUNT !== 5'd0) begin
            bad++;
            $display("FAIL ovf_end: tx=%b busy=%b ovf=%b count=%0d want 1 0 1 0",
                     txLog[682], OUT_BUSY, OUT_OVERFLOW, OUT_COUNT);
        end
    endtask

    task automatic test_full_boundary();
        do_reset();
        for (int i = 0; i < 17; i++) write_byte(8'h80 + 8'(i));
        total++;
        if (OUT_COUNT !== 5'd16 || OUT_FULL !== 1'b1 || OUT_OVERFLOW !== 1'b0) begin
            bad++;
            $display("FAIL fb_fill: count=%0d full=%b ovf=%b want 16 1 0", OUT_COUNT, OUT_FULL, OUT_OVERFLOW);
        end
        for (int i = 0; i < 24; i++) tick();
        total++;
        if (OUT_COUNT !== 5'd16) begin
            bad++;
            $display("FAIL fb_hold: count=%0d want 16", OUT_COUNT);
        end
        write_byte(8'hEE);
        total++;
        if (OUT_COUNT !== 5'd15 || OUT_OVERFLOW !== 1'b1 || OUT_FULL !== 1'b0) begin
            bad++;
            $display("FAIL fb_pushpop: count=%0d ovf=%b full=%b want 15 1 0", OUT_COUNT, OUT_OVERFLOW, OUT_FULL);
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        write_byte(8'hC3);
        for (int i = 0; i < 19; i++) tick();
        total++;
        if (OUT_SERIAL_TX !== 1'b0 || OUT_BUSY !== 1'b1) begin
            bad++;
            $display("FAIL mid_bit3: tx=%b busy=%b want 0 1", OUT_SERIAL_TX, OUT_BUSY);
        end
        #1;
        RESET = 1'b1;
        #1;
        total++;
        if ({OUT_SERIAL_TX, OUT_BUSY, OUT_EMPTY, OUT_OVERFLOW, OUT_COUNT} !== {4'b1010, 5'd0}) begin
            bad++;
            $display("FAIL mid_async: tx/busy/empty/ovf=%b%b%b%b count=%0d want 1010/0",
                     OUT_SERIAL_TX, OUT_BUSY, OUT_EMPTY, OUT_OVERFLOW, OUT_COUNT);
        end
        #3;
        RESET = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            total++;
            if (OUT_SERIAL_TX !== 1'b1 || OUT_BUSY !== 1'b0) begin
                bad++;
                $display("FAIL mid_residual cyc%0d: tx=%b busy=%b want 1 0", i, OUT_SERIAL_TX, OUT_BUSY);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_boundary();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
